popcnt_unary_gen: RTL and testbench

Sequential count-to-unary generator: the inverse of the team's carry-save popcount tree. It accepts a binary count `in_count` through a valid/ready handshake. It then builds a DEPTH-bit thermometer vector containing exactly that many ones, one bit per cycle, and emits one unary pulse per bit. It presents the finished vector on a valid/ready output. It sits on the producer side of any path that is later checked by the popcount tree, such as credit/token generation or self-test, so that popcount(`therm`) equals the accepted count.

---
 rtl/popcnt_unary_gen.sv | 59 +++++
 tb/tb_popcnt_unary_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/popcnt_unary_gen.sv
// popcnt_unary_gen: turns a binary count into a thermometer vector, one bit and one pulse per cycle
module popcnt_unary_gen #(
  parameter int DEPTH = 8,
  parameter int WIDTH = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_count,
  output logic             pulse,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DEPTH-1:0] therm,
  output logic             sat
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [WIDTH-1:0] dmax = WIDTH'(DEPTH);
  logic [1:0] state, nxt;
  logic [WIDTH-1:0] rem, clamp;
  logic over;
  always_comb begin
    over  = in_count > dmax;
    clamp = over ? dmax : in_count;
    nxt   = state == IDLE  ? (in_valid ? (clamp != '0 ? SHIFT : DONE) : IDLE) :
            state == SHIFT ? (rem == WIDTH'(1) ? DONE : SHIFT) :
            state == DONE  ? (out_ready ? IDLE : DONE) : IDLE;
  end
  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem       <= '0;
      therm     <= '0;
      sat       <= 1'b0;
      pulse     <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= nxt;
      pulse     <= nxt == SHIFT;
      out_valid <= nxt == DONE;
      in_ready  <= nxt == IDLE;
      busy      <= nxt != IDLE;
      if (state == IDLE && in_valid) begin
        rem   <= clamp;
        sat   <= over;
        therm <= '0;
      end else if (state == SHIFT) begin
        therm <= {therm[DEPTH-2:0], 1'b1};
        rem   <= rem - WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_popcnt_unary_gen.sv
// tb_popcnt_unary_gen: directed and randomized checks of popcnt_unary_gen against a count-based model
module tb_popcnt_unary_gen;
  localparam int DEPTH = 8;
  localparam int WIDTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [WIDTH-1:0] in_count = '0;
  logic out_ready = 1'b1;
  logic in_ready, pulse, busy, out_valid, sat;
  logic [DEPTH-1:0] therm;
  int vectors = 0;
  int fails = 0;

  popcnt_unary_gen #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
    .pulse(pulse), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .therm(therm), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int pulses;
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if ({in_ready, busy, pulse, out_valid, sat} !== 5'b10000 || therm !== '0) begin
      fails++;
      $display("FAIL reset: ready/busy/pulse/valid/sat=%b therm=%h, need 10000 and 00",
               {in_ready, busy, pulse, out_valid, sat}, therm);
    end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pulse !== 1'b0 || in_ready !== 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL idle: %0d cycles with pulse or not ready, need 0", pulses);
    end
  endtask

  // Model: N = min(count, DEPTH); N contiguous pulses, out_valid N edges after acceptance,
  // therm = 2^N-1, sat = count > DEPTH, ready again one edge after the output handshake.
  task automatic run_txn(input int cnt, input int hold);
    int n, k, pulses, guard;
    bit bad;
    logic [DEPTH-1:0] exp_t;
    n = cnt > DEPTH ? DEPTH : cnt;
    exp_t = DEPTH'((1 << n) - 1);
    out_ready = (hold == 0);
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (in_ready !== 1'b1) begin
      vectors++;
      fails++;
      $display("FAIL ready_timeout: in_ready=%b, need 1", in_ready);
      return;
    end
    in_valid = 1'b1;
    in_count = WIDTH'(cnt);
    tick();
    in_valid = 1'b0;
    in_count = WIDTH'($urandom);
    k = 0;
    pulses = 0;
    bad = 0;
    while (out_valid !== 1'b1 && k < 40) begin
      if (pulse !== (k < n)) bad = 1;
      if (pulse === 1'b1) pulses++;
      tick();
      k++;
    end
    if (pulse !== 1'b0) bad = 1;
    vectors++;
    if (out_valid !== 1'b1 || k != n) begin
      fails++;
      $display("FAIL latency cnt=%0d: out_valid=%b after %0d edges, need 1 after %0d", cnt, out_valid, k, n);
    end
    vectors++;
    if (pulses != n || bad) begin
      fails++;
      $display("FAIL pulses cnt=%0d: %0d pulses (shape_err=%0d), need %0d contiguous", cnt, pulses, bad, n);
    end
    vectors++;
    if (therm !== exp_t || sat !== (cnt > DEPTH) || $countones(therm) != n) begin
      fails++;
      $display("FAIL result cnt=%0d: therm=%h sat=%b, need therm=%h sat=%b", cnt, therm, sat, exp_t, cnt > DEPTH);
    end
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL done_flags cnt=%0d: in_ready=%b busy=%b, need 0 1", cnt, in_ready, busy);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_count = WIDTH'($urandom);
      tick();
      vectors++;
      if (therm !== exp_t || out_valid !== 1'b1 || in_ready !== 1'b0 || pulse !== 1'b0) begin
        fails++;
        $display("FAIL hold cnt=%0d cyc=%0d: therm=%h valid=%b ready=%b pulse=%b, need %h 1 0 0",
                 cnt, i, therm, out_valid, in_ready, pulse, exp_t);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || therm !== exp_t) begin
      fails++;
      $display("FAIL handshake cnt=%0d: ready=%b valid=%b busy=%b therm=%h, need 1 0 0 %h",
               cnt, in_ready, out_valid, busy, therm, exp_t);
    end
  endtask

  task automatic test_count5();
    run_txn(5, 0);
  endtask

  task automatic test_zero_full();
    run_txn(0, 0);
    run_txn(8, 0);
  endtask

  task automatic test_clamp();
    run_txn(12, 0);
    run_txn(15, 0);
  endtask

  task automatic test_hold();
    run_txn(3, 10);
  endtask

  task automatic test_reset_mid();
    int seen;
    tick();
    in_valid = 1'b1;
    in_count = 4'd6;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    vectors++;
    if (pulse !== 1'b1 || therm !== 8'h03) begin
      fails++;
      $display("FAIL mid_shift: pulse=%b therm=%h, need 1 03", pulse, therm);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if ({pulse, busy, out_valid, in_ready} !== 4'b0001 || therm !== '0) begin
      fails++;
      $display("FAIL rst_shift: pulse/busy/valid/ready=%b therm=%h, need 0001 00",
               {pulse, busy, out_valid, in_ready}, therm);
    end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid !== 1'b0 || pulse !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin
      fails++;
      $display("FAIL rst_quiet: %0d cycles with valid or pulse, need 0", seen);
    end
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_count = 4'd12;
    tick();
    in_valid = 1'b0;
    seen = 0;
    while (out_valid !== 1'b1 && seen < 40) begin
      tick();
      seen++;
    end
    out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({out_valid, in_ready, busy, sat} !== 4'b0100 || therm !== '0) begin
      fails++;
      $display("FAIL rst_done: valid/ready/busy/sat=%b therm=%h, need 0100 00",
               {out_valid, in_ready, busy, sat}, therm);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++)
      run_txn($urandom_range(0, 15), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
  endtask

  initial begin
    test_reset();
    test_count5();
    test_zero_full();
    test_clamp();
    test_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
